list_fold: RTL and testbench

- Consumer (initiator) end of the lazy-list req/ack/value/value_valid stream protocol.
- Repeatedly pulls elements from any list producer, such as an enumerator, cons, concat or list mux output, and reduces them into one scalar.
- Supported reductions: signed sum, max, min, or length.
- Synthesised for list-consuming builtins (sum/maximum/minimum/length). Result and done are presented to surrounding generated code, with the same done semantics as the deconstructor.

---
 rtl/list_fold_pkg.sv | 27 ++
 rtl/list_fold_alu.sv | 24 ++
 rtl/list_fold.sv | 157 +++++++++++++++
 tb/tb_list_fold.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/list_fold_pkg.sv
// rtl/list_fold_pkg.sv - shared types and signed identity helpers for the list fold consumer
package list_fold_pkg;

  typedef enum logic [1:0] {
    FOLD_SUM = 2'd0,
    FOLD_MAX = 2'd1,
    FOLD_MIN = 2'd2,
    FOLD_LEN = 2'd3
  } fold_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } fold_state_t;

  // Most negative / most positive w-bit value, sign-extended to 64 bits; callers truncate.
  function automatic logic [63:0] smin_ext(input int w);
    return ~((64'd1 << (w - 1)) - 64'd1);
  endfunction

  function automatic logic [63:0] smax_ext(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/list_fold_alu.sv
// rtl/list_fold_alu.sv - combinational accumulator step for sum/max/min/length folds
module list_fold_alu
  import list_fold_pkg::*;
#(
  parameter int ACC_WIDTH = 16
) (
  input  fold_op_t               op_i,
  input  logic [ACC_WIDTH-1:0]   acc_i,
  input  logic [ACC_WIDTH-1:0]   val_i,
  output logic [ACC_WIDTH-1:0]   acc_o
);

  // Ties keep the current accumulator; length is carried by the element counter instead.
  always_comb begin
    acc_o = acc_i;
    case (op_i)
      FOLD_SUM: acc_o = acc_i + val_i;
      FOLD_MAX: if ($signed(val_i) > $signed(acc_i)) acc_o = val_i;
      FOLD_MIN: if ($signed(val_i) < $signed(acc_i)) acc_o = val_i;
      default:  acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/list_fold.sv
// rtl/list_fold.sv - lazy-list consumer reducing a req/ack element stream to sum/max/min/length
// Define LIST_FOLD_TIMEOUT_EN to add the per-request ack timeout and the timeout output.
module list_fold
  import list_fold_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clock,
  input  logic                 ready,
  input  logic [1:0]           op,
  output logic                 list_req,
  input  logic                 list_ack,
  input  logic [WIDTH-1:0]     list_value,
  input  logic                 list_value_valid,
  output logic [ACC_WIDTH-1:0] result,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 empty,
`ifdef LIST_FOLD_TIMEOUT_EN
  output logic                 timeout,
`endif
  output logic                 done
);

  if (ACC_WIDTH < WIDTH || TIMEOUT < 1) begin : g_param_check
    $error("list_fold: ACC_WIDTH must be >= WIDTH and TIMEOUT >= 1");
  end

  localparam logic [63:0] SMIN64 = smin_ext(WIDTH);
  localparam logic [63:0] SMAX64 = smax_ext(WIDTH);
  localparam logic [ACC_WIDTH-1:0] ID_MAX = SMIN64[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] ID_MIN = SMAX64[ACC_WIDTH-1:0];

  fold_state_t            state_q, state_d;
  fold_op_t               op_q, op_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d, res_q, res_d, acc_step;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   req_q, req_d, empty_q, empty_d;
  logic [ACC_WIDTH-1:0]   val_ext;

`ifdef LIST_FOLD_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              to_q, to_d;
`endif

  assign val_ext = ACC_WIDTH'($signed(list_value));

  list_fold_alu #(.ACC_WIDTH(ACC_WIDTH)) u_alu (
    .op_i  (op_q),
    .acc_i (acc_q),
    .val_i (val_ext),
    .acc_o (acc_step)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    empty_d = empty_q;
`ifdef LIST_FOLD_TIMEOUT_EN
    wait_d  = wait_q;
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: begin
        op_d  = fold_op_t'(op);
        cnt_d = '0;
        case (fold_op_t'(op))
          FOLD_MAX: acc_d = ID_MAX;
          FOLD_MIN: acc_d = ID_MIN;
          default:  acc_d = '0;
        endcase
        state_d = REQ;
`ifdef LIST_FOLD_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      REQ: begin
        if (list_ack) begin
          if (list_value_valid) begin
            acc_d   = acc_step;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            state_d = GAP;
          end else begin
            // An empty list reports 0 so the max/min identity never leaks out.
            empty_d = (cnt_q == '0);
            if (cnt_q == '0)          res_d = '0;
            else if (op_q == FOLD_LEN) res_d = ACC_WIDTH'(cnt_q);
            else                       res_d = acc_q;
            state_d = DONE;
          end
        end
`ifdef LIST_FOLD_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          res_d   = '0;
          empty_d = 1'b0;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      GAP: begin
        state_d = REQ;
`ifdef LIST_FOLD_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      default: state_d = DONE;
    endcase
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clock) begin
    if (!ready) begin
      state_q <= IDLE;
      op_q    <= FOLD_SUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      req_q   <= 1'b0;
      empty_q <= 1'b0;
`ifdef LIST_FOLD_TIMEOUT_EN
      wait_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      req_q   <= req_d;
      empty_q <= empty_d;
`ifdef LIST_FOLD_TIMEOUT_EN
      wait_q  <= wait_d;
      to_q    <= to_d;
`endif
    end
  end

  assign list_req = req_q;
  assign result   = res_q;
  assign count    = cnt_q;
  assign empty    = empty_q;
  assign done     = (state_q == DONE);
`ifdef LIST_FOLD_TIMEOUT_EN
  assign timeout  = to_q;
`endif

endmodule

// File: tb/tb_list_fold.sv
// tb/tb_list_fold.sv - randomized bench for list_fold with a registered list producer and fold model
module tb_list_fold;

  localparam int W  = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                ready;
  logic [1:0]          op;
  logic [1:0]          req_v, ack_v, vv_v, done_v, empty_v, prev_v;
  logic [1:0][W-1:0]   val_v;
  logic [1:0][CW-1:0]  cnt_v;
  logic [15:0]         res16;
  logic [7:0]          res8;
`ifdef LIST_FOLD_TIMEOUT_EN
  logic [1:0]          to_v;
`endif

  int          lst[$];
  int          idx[2];
  int          rises[2];
  bit          mute;
  int          errors = 0;
  int          checks = 0;
  bit          cmp_en;
  logic [15:0] exp_res[2];
  int          exp_cnt;
  bit          exp_empty;

  list_fold #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8), .TIMEOUT(4)) u_dut16 (
    .clock(clk), .ready(ready), .op(op), .list_req(req_v[0]), .list_ack(ack_v[0]),
    .list_value(val_v[0]), .list_value_valid(vv_v[0]), .result(res16), .count(cnt_v[0]),
    .empty(empty_v[0]),
`ifdef LIST_FOLD_TIMEOUT_EN
    .timeout(to_v[0]),
`endif
    .done(done_v[0])
  );

  list_fold #(.WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(8), .TIMEOUT(4)) u_dut8 (
    .clock(clk), .ready(ready), .op(op), .list_req(req_v[1]), .list_ack(ack_v[1]),
    .list_value(val_v[1]), .list_value_valid(vv_v[1]), .result(res8), .count(cnt_v[1]),
    .empty(empty_v[1]),
`ifdef LIST_FOLD_TIMEOUT_EN
    .timeout(to_v[1]),
`endif
    .done(done_v[1])
  );

  // Registered producer: answers each rising edge of req on the next cycle; injects stray acks
  // only while the consumer is not requesting (gap after a handshake, or done).
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!ready || mute) begin
        ack_v[d]  <= 1'b0;
        vv_v[d]   <= 1'b0;
        prev_v[d] <= 1'b0;
        if (!ready) begin
          idx[d]   <= 0;
          rises[d] <= 0;
        end
      end else begin
        prev_v[d] <= req_v[d];
        val_v[d]  <= 8'($urandom);
        vv_v[d]   <= 1'($urandom);
        ack_v[d]  <= 1'b0;
        if (req_v[d] && !prev_v[d]) begin
          ack_v[d]   <= 1'b1;
          rises[d]   <= rises[d] + 1;
          if (idx[d] < lst.size()) begin
            vv_v[d]  <= 1'b1;
            val_v[d] <= 8'(lst[idx[d]]);
            idx[d]   <= idx[d] + 1;
          end else begin
            vv_v[d]  <= 1'b0;
          end
        end else if ((req_v[d] && prev_v[d]) || done_v[d]) begin
          if ($urandom_range(0, 2) == 0) begin
            ack_v[d] <= 1'b1;
            vv_v[d]  <= 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] o, input int aw);
    longint acc;
    longint modv;
    int     n;
    n    = lst.size();
    modv = longint'(1) << aw;
    if (n == 0) return 16'd0;
    acc = 0;
    case (o)
      2'd0: foreach (lst[i]) acc += lst[i];
      2'd1: begin acc = lst[0]; foreach (lst[i]) if (lst[i] > acc) acc = lst[i]; end
      2'd2: begin acc = lst[0]; foreach (lst[i]) if (lst[i] < acc) acc = lst[i]; end
      default: acc = (n > 255) ? 255 : n;
    endcase
    acc = acc % modv;
    if (acc < 0) acc += modv;
    return 16'(acc);
  endfunction

  always @(negedge clk) begin
    if (cmp_en && ready) begin
      if (done_v[0]) begin
        chk("res16", 32'(res16), 32'(exp_res[0]));
        chk("cnt16", 32'(cnt_v[0]), 32'(exp_cnt));
        chk("empty16", 32'(empty_v[0]), 32'(exp_empty));
        chk("req16_done", 32'(req_v[0]), 32'd0);
`ifdef LIST_FOLD_TIMEOUT_EN
        chk("to16_clear", 32'(to_v[0]), 32'd0);
`endif
      end
      if (done_v[1]) begin
        chk("res8", 32'(res8), 32'(exp_res[1][7:0]));
        chk("cnt8", 32'(cnt_v[1]), 32'(exp_cnt));
        chk("empty8", 32'(empty_v[1]), 32'(exp_empty));
        chk("req8_done", 32'(req_v[1]), 32'd0);
      end
    end
  end

  task automatic run(input logic [1:0] o);
    int n;
    int cyc;
    n   = lst.size();
    cyc = 0;
    cmp_en = 1'b0;
    @(negedge clk);
    ready        = 1'b0;
    op           = o;
    exp_res[0]   = model(o, 16);
    exp_res[1]   = model(o, 8);
    exp_cnt      = (n > 255) ? 255 : n;
    exp_empty    = (n == 0);
    @(negedge clk);
    ready  = 1'b1;
    cmp_en = 1'b1;
    while (!(done_v[0] && done_v[1]) && cyc < 3 * n + 12) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) op = 2'($urandom);
    end
    chk("latency", 32'(cyc), 32'(3 * n + 3));
    chk("rises16", 32'(rises[0]), 32'(n + 1));
    chk("rises8", 32'(rises[1]), 32'(n + 1));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cyc;
    int n;
    ready  = 1'b0;
    op     = 2'd0;
    mute   = 1'b0;
    cmp_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs16", 32'({req_v[0], done_v[0], empty_v[0], cnt_v[0], res16}), 32'd0);
    chk("rst_outs8", 32'({req_v[1], done_v[1], empty_v[1], cnt_v[1], res8}), 32'd0);

    lst = '{-3, -1, 1, 3, 5};
    run(2'd0);
    chk("plan_sum", 32'(res16), 32'd5);
    chk("plan_sum_cnt", 32'(cnt_v[0]), 32'd5);
    chk("plan_sum_empty", 32'(empty_v[0]), 32'd0);
    run(2'd1);
    chk("plan_max", 32'(res16), 32'd5);
    run(2'd2);
    chk("plan_min16", 32'(res16), 32'h0000FFFD);
    chk("plan_min8", 32'(res8), 32'h000000FD);
    run(2'd3);
    chk("plan_len", 32'(res16), 32'd5);

    lst = {};
    for (int o = 0; o < 4; o++) begin
      run(2'(o));
      chk("empty_flag", 32'(empty_v[0]), 32'd1);
      chk("empty_res", 32'(res16), 32'd0);
    end

    lst = '{100, 100};
    run(2'd0);
    chk("wrap8", 32'(res8), 32'h000000C8);
    chk("nowrap16", 32'(res16), 32'd200);
    chk("wrap_cnt", 32'(cnt_v[1]), 32'd2);

    lst = '{7, -20, 33, 4, -1};
    cmp_en = 1'b0;
    @(negedge clk);
    ready = 1'b0;
    op    = 2'd0;
    @(negedge clk);
    ready = 1'b1;
    cyc   = 0;
    while (!(idx[0] == 3 && ack_v[0] && vv_v[0]) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach", 32'(cyc < 50), 32'd1);
    @(negedge clk);
    chk("abort_gap_req", 32'(req_v[0]), 32'd0);
    ready = 1'b0;
    @(negedge clk);
    chk("abort_clr16", 32'({req_v[0], done_v[0], empty_v[0], cnt_v[0], res16}), 32'd0);
    chk("abort_clr8", 32'({req_v[1], done_v[1], empty_v[1], cnt_v[1], res8}), 32'd0);
    run(2'd0);
    chk("abort_rerun", 32'(res16), 32'd23);
    chk("abort_rerun_cnt", 32'(cnt_v[0]), 32'd5);

    lst = {};
    for (int i = 0; i < 260; i++) lst.push_back($urandom_range(0, 255) - 128);
    run(2'd3);
    chk("sat_len", 32'(res16), 32'd255);
    run(2'($urandom_range(0, 2)));

    repeat (25) begin
      lst = {};
      n   = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 5))
          0:       lst.push_back(-128);
          1:       lst.push_back(127);
          default: lst.push_back($urandom_range(0, 255) - 128);
        endcase
      end
      run(2'($urandom));
    end

    cmp_en = 1'b0;
    lst    = {};
    mute   = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    ready = 1'b1;
`ifdef LIST_FOLD_TIMEOUT_EN
    cyc = 0;
    while (!done_v[0] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_latency", 32'(cyc), 32'd5);
    chk("to_flag", 32'(to_v[0]), 32'd1);
    chk("to_req", 32'(req_v[0]), 32'd0);
    chk("to_cnt", 32'(cnt_v[0]), 32'd0);
    chk("to_res", 32'(res16), 32'd0);
    chk("to_empty", 32'(empty_v[0]), 32'd0);
`else
    repeat (100) begin
      @(negedge clk);
      chk("hold_req", 32'(req_v[0]), 32'd1);
      chk("hold_done", 32'(done_v[0]), 32'd0);
    end
`endif
    mute  = 1'b0;
    ready = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
